// File: rtl/axi_enhanced_tx_pkg.sv
// Shared types and constants for the enhanced TX port arbiter/mux.
package axi_enhanced_tx_pkg;

  // Mux FSM: IDLE arbitrates, PKT streams the locked channel until tlast.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  // Channel 0 carries configuration TLPs and always wins arbitration.
  localparam int CH_CFG = 0;

  // tuser bit positions as seen by the TX pipeline.
  localparam int TUSER_DISCONTINUE = 0;
  localparam int TUSER_STREAMED    = 1;
  localparam int TUSER_ECRC_EN     = 2;
  localparam int TUSER_ERR_FWD     = 3;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_enhanced_tx_rr_arb.sv
// Round-robin search over channels 1..NUM_CH-1 starting at rr_ptr.
// Channel 0 is never a candidate here; its priority lives in the parent.
module axi_enhanced_tx_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   winner,
  output logic              found
);

  int idx;

  // First eligible channel at or after rr_ptr, wrapping NUM_CH-1 -> 1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - (NUM_CH - 1);
      if (!found && eligible[idx[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_enhanced_tx_port_arb_mux.sv
// NUM_CH-input AXI-S TLP arbiter and registered mux toward the TX pipeline.
// Channel 0 (CFG) has strict priority, the rest are round-robin, and a grant
// is held for a whole packet. Link-down discards input and flushes in-flight
// packets.
//
// Handshake: a beat transfers on any rising edge where tvalid and tready are
// both high; tvalid, once raised, is not expected to depend on tready, and
// the output register only changes when it is empty or being drained.
module axi_enhanced_tx_port_arb_mux
  import axi_enhanced_tx_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int NUM_CH       = 4,
  parameter int USER_WIDTH   = 4,
  parameter int TCQ          = 1,
  parameter int STRB_WIDTH   = C_DATA_WIDTH / 8,
  parameter int CH_W         = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                         com_iclk,
  input  logic                         com_sysrst_n,
  input  logic [NUM_CH*C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH*STRB_WIDTH-1:0] s_axis_tstrb,
  input  logic [NUM_CH*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH-1:0]            ch_thrtl,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [STRB_WIDTH-1:0]        m_axis_tstrb,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  input  logic                         trn_lnk_up,
  output logic [CH_W-1:0]              channel_sel,
  output logic                         flush_axis_tlp,
  output state_e                       dbg_state,
  output logic [CH_W-1:0]              dbg_rr_ptr
);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         channel_sel_q, channel_sel_d;
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    lnk_q, lnk_d;
  logic                    flush_q, flush_d;
  logic [C_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [STRB_WIDTH-1:0]   m_strb_q, m_strb_d;
  logic [USER_WIDTH-1:0]   m_user_q, m_user_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;

  logic [NUM_CH-1:0]       eligible;
  logic [NUM_CH-1:0]       tready_c;
  logic [CH_W-1:0]         rr_winner;
  logic                    rr_found;
  logic                    load;
  logic                    accept;
  logic                    sel_thrtl;

  // Throttle never applies to CFG; bit 0 is deliberately ignored.
  assign eligible = s_axis_tvalid & ~{ch_thrtl[NUM_CH-1:1], 1'b0};

  logic unused_ok;
  assign unused_ok = ^{ch_thrtl[0], TCQ};

  axi_enhanced_tx_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .winner   (rr_winner),
    .found    (rr_found)
  );

  // Next-state, output register loading and per-channel tready.
  always_comb begin
    state_d       = state_q;
    channel_sel_d = channel_sel_q;
    rr_ptr_d      = rr_ptr_q;
    lnk_d         = trn_lnk_up;
    m_data_d      = m_data_q;
    m_strb_d      = m_strb_q;
    m_user_d      = m_user_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    tready_c      = '0;
    accept        = 1'b0;
    load          = ~m_valid_q | m_axis_tready;
    sel_thrtl     = ch_thrtl[channel_sel_q] & (channel_sel_q != CH_W'(CH_CFG));
    // Falling link edge while a packet is open (in the FSM or the output reg).
    flush_d       = lnk_q & ~trn_lnk_up &
                    ((state_q == ST_PKT) | (m_valid_q & ~m_last_q));

    if (!trn_lnk_up) begin
      // Swallow everything upstream and drop the output beat.
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
      tready_c  = '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eligible[CH_CFG]) begin
            channel_sel_d = CH_W'(CH_CFG);
            state_d       = ST_PKT;
          end else if (rr_found) begin
            channel_sel_d = rr_winner;
            state_d       = ST_PKT;
          end
        end
        ST_PKT: begin
          tready_c[channel_sel_q] = load & ~sel_thrtl;
          accept = load & ~sel_thrtl & s_axis_tvalid[channel_sel_q];
          if (accept) begin
            m_data_d  = s_axis_tdata[int'(channel_sel_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
            m_strb_d  = s_axis_tstrb[int'(channel_sel_q)*STRB_WIDTH +: STRB_WIDTH];
            m_user_d  = s_axis_tuser[int'(channel_sel_q)*USER_WIDTH +: USER_WIDTH];
            m_last_d  = s_axis_tlast[channel_sel_q];
            m_valid_d = 1'b1;
            if (s_axis_tlast[channel_sel_q]) begin
              state_d = ST_IDLE;
              if (channel_sel_q != CH_W'(CH_CFG)) begin
                rr_ptr_d = (channel_sel_q == CH_W'(NUM_CH - 1)) ? CH_W'(1)
                                                                : channel_sel_q + CH_W'(1);
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load && !accept) m_valid_d = 1'b0;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      state_q       <= ST_IDLE;
      channel_sel_q <= '0;
      rr_ptr_q      <= CH_W'(1);
      lnk_q         <= 1'b0;
      flush_q       <= 1'b0;
      m_data_q      <= '0;
      m_strb_q      <= '0;
      m_user_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      channel_sel_q <= channel_sel_d;
      rr_ptr_q      <= rr_ptr_d;
      lnk_q         <= lnk_d;
      flush_q       <= flush_d;
      m_data_q      <= m_data_d;
      m_strb_q      <= m_strb_d;
      m_user_q      <= m_user_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
    end
  end

  // tready is combinational, so force it low while reset is held.
  assign s_axis_tready  = com_sysrst_n ? tready_c : '0;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tstrb   = m_strb_q;
  assign m_axis_tuser   = m_user_q;
  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tlast   = m_last_q;
  assign channel_sel    = channel_sel_q;
  assign flush_axis_tlp = flush_q;
  assign dbg_state      = state_q;
  assign dbg_rr_ptr     = rr_ptr_q;

endmodule

// File: doc/axi_enhanced_tx_port_arb_mux.md
Name: axi_enhanced_tx_port_arb_mux

Overview:
- N-channel successor to the fixed 4-port TX port mux, with the arbiter folded in.
- Merges NUM_CH AXI-S TLP sources into one registered AXI-S stream toward the TX pipeline.
- Arbitration: channel 0 (CFG) has strict priority; channels 1..NUM_CH-1 are round-robin; a grant is locked for a whole packet.
- Per-channel throttle inputs. On link-down, discards in-flight TLPs and pulses a flush flag.

Parameters:
- C_DATA_WIDTH, 64: data width per channel; legal values 32/64/128.
- NUM_CH, 4: number of input channels, 2..8; channel 0 is CFG.
- USER_WIDTH, 4: tuser width.
- TCQ, 1: clock-to-Q delay.
- STRB_WIDTH, C_DATA_WIDTH/8: derived, do not override.
- CH_W, max(1, clog2(NUM_CH)): derived, do not override.

Ports:
- com_iclk  in  1  clock
- com_sysrst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  NUM_CH*C_DATA_WIDTH  per-channel data; channel i occupies slice i
- s_axis_tstrb  in  NUM_CH*STRB_WIDTH  per-channel strobes
- s_axis_tuser  in  NUM_CH*USER_WIDTH  per-channel user bits
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tlast  in  NUM_CH  per-channel last
- s_axis_tready  out  NUM_CH  per-channel ready
- ch_thrtl  in  NUM_CH  throttle request; bit 0 is ignored
- m_axis_tdata/tstrb/tuser  out  C_DATA_WIDTH/STRB_WIDTH/USER_WIDTH  muxed output, registered
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output last
- m_axis_tready  in  1  ready from TX pipeline
- trn_lnk_up  in  1  link up
- channel_sel  out  CH_W  current grant, registered
- flush_axis_tlp  out  1  one-cycle pulse on link-down mid-packet

Behaviour:
- Reset values: all m_axis_* = 0; s_axis_tready = 0; channel_sel = 0; flush_axis_tlp = 0; state = IDLE; rr_ptr = 1; lnk_q = 0.
- States: IDLE, PKT.
- IDLE, link up, winner selection:
  - Eligible channel = tvalid & ~ch_thrtl; channel 0 is always eligible when valid.
  - Winner = channel 0 if eligible; otherwise the first eligible channel at or after rr_ptr, wrapping from NUM_CH-1 to 1.
  - On a winner: channel_sel <= winner, go to PKT. No input beat is accepted during the IDLE cycle (one-cycle arbitration bubble).
- IDLE, no eligible channel: remain in IDLE.
- PKT state:
  - load = ~m_axis_tvalid | m_axis_tready.
  - s_axis_tready[channel_sel] = load & trn_lnk_up & ~(ch_thrtl[channel_sel] & channel_sel!=0). All other tready bits are 0.
  - On an accepted beat: output register <= channel beat, m_axis_tvalid <= 1.
  - load with no accepted beat: m_axis_tvalid <= 0.
  - Throttle asserted mid-packet: stalls the channel only; the lock is kept.
- End of packet: beat with tlast accepted -> IDLE. If channel_sel != 0, rr_ptr <= channel_sel+1, wrapping to 1. CFG grants never move rr_ptr.
- Latency: first beat visible on m_axis 2 cycles after tvalid rises on an idle mux with m_axis_tready=1. Steady state is 1 beat/cycle within a packet.
- Back-to-back single-beat packets: 1 packet per 2 cycles.
- Output stalls: while m_axis_tvalid & ~m_axis_tready, the output register holds and all tready are 0.
- lnk_q <= trn_lnk_up every cycle.
- Link down (trn_lnk_up = 0):
  - state <= IDLE; m_axis_tvalid <= 0.
  - All s_axis_tready = 1, discarding input beats.
  - No arbitration while the link is down.
- Flush pulse: when lnk_q & ~trn_lnk_up, flush_axis_tlp <= 1 for exactly one cycle if (state==PKT) or (m_axis_tvalid & ~m_axis_tlast). Otherwise it stays 0.
- Link return: arbitration resumes the cycle after trn_lnk_up returns; rr_ptr is preserved.
- Reset assertion mid-packet: all outputs go to reset values immediately. No flush pulse.

Decomposition:
- Shared package axi_enhanced_tx_pkg holds:
  - state encodings ST_IDLE/ST_PKT;
  - CH_CFG = 0;
  - a clog2 function;
  - tuser bit-position constants (discontinue, streamed, ECRC, etc.).
- Sub-module axi_enhanced_tx_rr_arb (params NUM_CH, CH_W) is natural.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: winner index and a found flag. Purely combinational.
  - Priority-0 override and pointer update stay in the parent.

Test Plan:
- Single channel: ch2 sends a 3-beat TLP (D0..D2), m_axis_tready=1 -> m_axis carries D0,D1,D2 on cycles 2,3,4 after tvalid; tlast on D2; channel_sel=2; rr_ptr becomes 3.
- Round-robin fairness: ch1, ch2, ch3 continuously valid with 1-beat TLPs, rr_ptr=1 -> grant order 1,2,3,1,2,3; no channel interleaving within a packet.
- CFG priority: ch0 raises valid while ch3 is mid-packet (beat 2 of 4) -> ch3 completes all 4 beats, then ch0 is granted next ahead of ch1; rr_ptr is unchanged by the ch0 grant.
- Throttle and back-pressure:
  - ch_thrtl[1]=1 while ch1 holds a 4-beat packet -> tready[1]=0 and the output drains; lock is held; resumes on deassert with no beat lost.
  - m_axis_tready=0 for 3 cycles -> output holds its value and all tready=0.
- Link-down mid-packet: trn_lnk_up falls after beat 2 of a 5-beat ch2 TLP -> flush_axis_tlp=1 for exactly 1 cycle; m_axis_tvalid=0 next cycle; tready=all-ones while down. Link-down while IDLE -> no flush.
- Async reset: com_sysrst_n pulsed low mid-packet off the clock edge -> all outputs reach reset values before the next edge.
